// File: rtl/shake_arb_pkg.sv
// Shared definitions for the SHAKE sponge arbiter.
// Contents:
//   arb_state_e           arbiter FSM state encoding (IDLE, FLUSH, OWN)
//   DEF_*                 default widths and requester count
//   idx_w()               index width for a requester count (at least 1 bit)
package shake_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    OWN   = 2'd2
  } arb_state_e;

  localparam int DEF_NREQ          = 4;
  localparam int DEF_DATA_IN_BITS  = 64;
  localparam int DEF_DATA_OUT_BITS = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shake_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches i_req upward starting at i_ptr, wrapping at NREQ, and returns the
// first set bit.
// Ports:
//   i_req    [NREQ-1:0]   request vector
//   i_ptr    [IDX_W-1:0]  search start index (0..NREQ-1)
//   o_idx    [IDX_W-1:0]  winning index (0 when nothing is found)
//   o_found               at least one request bit is set
module rr_pick
  import shake_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // base and off are both below NREQ, so one conditional subtract suffices.
  function automatic int wrap_add(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NREQ) ? (s - NREQ) : s;
  endfunction

  // Walk the offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[wrap_add(int'(i_ptr), i)]) begin
        o_idx   = IDX_W'(wrap_add(int'(i_ptr), i));
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shake_arbiter.sv
// Round-robin arbiter sharing one SHAKE sponge among NREQ sampler controllers.
// A grant hands the sponge to one requester, first flushing it for one cycle,
// and holds it until that requester pulses its release line.
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   req, rel                   per-requester request (level) and release (pulse)
//   gnt, busy, owner           registered one-hot grant, grant in progress, owner index
//   r_*  (inputs)              per-requester sponge controls and packed data / last_len
//   r_data_out                 sponge output broadcast to every requester
//   r_out_valid, r_in_ready    sponge handshakes gated to the owner
//   sp_rst, sp_cache_rst       active-high sponge and sponge-cache resets
//   sp_* (outputs)             sponge request side, driven by the owner in OWN
//   sp_data_out, sp_out_valid, sp_in_ready   sponge response side
module shake_arbiter
  import shake_arb_pkg::*;
#(
  parameter int NREQ          = DEF_NREQ,
  parameter int DATA_IN_BITS  = DEF_DATA_IN_BITS,
  parameter int DATA_OUT_BITS = DEF_DATA_OUT_BITS,
  parameter int LEN_W         = $clog2(DATA_IN_BITS) + 1
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              rel,
  output logic [NREQ-1:0]              gnt,
  output logic                         busy,
  output logic [idx_w(NREQ)-1:0]       owner,

  input  logic [NREQ-1:0]              r_absorb_next_poly,
  input  logic [NREQ-1:0]              r_in_valid,
  input  logic [NREQ-1:0]              r_in_last,
  input  logic [NREQ-1:0]              r_cache_rd,
  input  logic [NREQ-1:0]              r_cache_wr,
  input  logic [NREQ-1:0]              r_out_ready,
  input  logic [NREQ*DATA_IN_BITS-1:0] r_data_in,
  input  logic [NREQ*LEN_W-1:0]        r_last_len,
  output logic [DATA_OUT_BITS-1:0]     r_data_out,
  output logic [NREQ-1:0]              r_out_valid,
  output logic [NREQ-1:0]              r_in_ready,

  output logic                         sp_rst,
  output logic                         sp_cache_rst,
  output logic [DATA_IN_BITS-1:0]      sp_data_in,
  output logic                         sp_in_valid,
  output logic                         sp_in_last,
  output logic [LEN_W-1:0]             sp_last_len,
  output logic                         sp_cache_rd,
  output logic                         sp_cache_wr,
  output logic                         sp_out_ready,
  input  logic [DATA_OUT_BITS-1:0]     sp_data_out,
  input  logic                         sp_out_valid,
  input  logic                         sp_in_ready
);

  localparam int IDX_W = idx_w(NREQ);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [NREQ-1:0]  r_gnt;

  logic [IDX_W-1:0] w_win;
  logic             w_found;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [NREQ-1:0]  w_owner_oh;
  logic             w_own;
  logic             w_take;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  // Explicit wrap keeps non-power-of-two NREQ correct.
  assign w_ptr_nxt  = (w_win == IDX_W'(NREQ - 1)) ? '0 : (w_win + 1'b1);
  assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_own      = (r_state == OWN);
  assign w_take     = (r_state == IDLE) && w_found;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found)      w_state_nxt = FLUSH;
      FLUSH:                     w_state_nxt = OWN;
      OWN:     if (rel[r_owner]) w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  // The owner is latched at sampling time, so it is already valid in FLUSH
  // and the grant can be registered straight from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_owner  <= w_win;
        r_rr_ptr <= w_ptr_nxt;
      end
      r_gnt <= (w_state_nxt == OWN) ? w_owner_oh : '0;
    end
  end

  assign gnt   = r_gnt;
  assign busy  = (r_state != IDLE);
  assign owner = r_owner;

  // Request-side mux: owner's controls in OWN, all zero otherwise.
  always_comb begin
    sp_data_in   = '0;
    sp_in_valid  = 1'b0;
    sp_in_last   = 1'b0;
    sp_last_len  = '0;
    sp_cache_rd  = 1'b0;
    sp_cache_wr  = 1'b0;
    sp_out_ready = 1'b0;
    if (w_own) begin
      sp_data_in   = r_data_in[int'(r_owner)*DATA_IN_BITS +: DATA_IN_BITS];
      sp_in_valid  = r_in_valid[r_owner];
      sp_in_last   = r_in_last[r_owner];
      sp_last_len  = r_last_len[int'(r_owner)*LEN_W +: LEN_W];
      sp_cache_rd  = r_cache_rd[r_owner];
      sp_cache_wr  = r_cache_wr[r_owner];
      sp_out_ready = r_out_ready[r_owner];
    end
  end

  // The sponge sits in reset for the whole arbiter reset, not just until the
  // flops settle, hence the direct term from rst.
  assign sp_rst       = ~rst | (r_state == FLUSH) | (w_own & r_absorb_next_poly[r_owner]);
  assign sp_cache_rst = ~rst;

  assign r_data_out  = sp_data_out;
  assign r_out_valid = {NREQ{sp_out_valid}} & r_gnt;
  assign r_in_ready  = {NREQ{sp_in_ready}} & r_gnt;

endmodule
